// File: rtl/mont_conv.sv
// Montgomery domain converter: x -> x*R mod Q (TO_MONT) or x*R^-1 mod Q (FROM_MONT),
// using a bit-serial radix-2 Montgomery multiply by a constant k (R2 or 1).
// Optional macro MONT_CONV_INRED_EN adds a REDUCE state that folds x >= Q into range.
// Latency from the accept edge (counted as edge 1) to the edge on which out_valid rises is
// WIDTH+2 edges, or WIDTH+3 with MONT_CONV_INRED_EN.

package ntt_pkg;
    localparam int DATA_WIDTH = 12;
    localparam int Q          = 3329;
endpackage

module mont_conv
    import ntt_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam int              IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH:0]  QW    = (WIDTH+1)'(Q);
    localparam longint          R2_L  = (longint'(1) << (2 * WIDTH)) % longint'(Q);
    localparam logic [WIDTH-1:0] R2   = WIDTH'(R2_L);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [IW-1:0]   LAST  = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef MONT_CONV_INRED_EN
        REDUCE,
`endif
        RUN,
        CORR,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] x_reg, x_next;
    logic [WIDTH-1:0] k_reg, k_next;
    logic [WIDTH:0]   s_reg, s_next;
    logic [IW-1:0]    i_reg, i_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic             out_valid_reg, out_valid_next;

    // Step sum needs two bits of headroom: S < 2Q, plus x < R, plus Q.
    logic [WIDTH+1:0] t;
    logic [WIDTH:0]   s_sub;
    logic [WIDTH:0]   x_sub;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign s_sub     = s_reg - QW;
    assign x_sub     = {1'b0, x_reg} - QW;

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            k_reg         <= '0;
            s_reg         <= '0;
            i_reg         <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            k_reg         <= k_next;
            s_reg         <= s_next;
            i_reg         <= i_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
        end
    end

    // Next-state and datapath: one radix-2 Montgomery step per RUN cycle.
    always_comb begin
        state_next     = state_reg;
        x_next         = x_reg;
        k_next         = k_reg;
        s_next         = s_reg;
        i_next         = i_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        t              = '0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    x_next = in_data;
                    k_next = in_mode ? ONE : R2;
                    s_next = '0;
                    i_next = '0;
`ifdef MONT_CONV_INRED_EN
                    state_next = REDUCE;
`else
                    state_next = RUN;
`endif
                end
            end
`ifdef MONT_CONV_INRED_EN
            REDUCE: begin
                // Q > R/2, so one conditional subtraction brings any x into 0..Q-1.
                if ({1'b0, x_reg} >= QW) begin
                    x_next = x_sub[WIDTH-1:0];
                end
                state_next = RUN;
            end
`endif
            RUN: begin
                t = {1'b0, s_reg} + (k_reg[i_reg] ? {2'b00, x_reg} : '0);
                if (t[0]) begin
                    t = t + {1'b0, QW};
                end
                s_next = t[WIDTH+1:1];
                i_next = i_reg + IW'(1);
                if (i_reg == LAST) begin
                    state_next = CORR;
                end
            end
            CORR: begin
                // S < 2Q here, so a single subtraction lands in 0..Q-1.
                out_data_next  = (s_reg >= QW) ? s_sub[WIDTH-1:0] : s_reg[WIDTH-1:0];
                out_valid_next = 1'b1;
                state_next     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mont_conv.sv
// Self-checking bench for mont_conv (Q=3329, WIDTH=12): directed table, stall,
// mid-operation reset, out-of-range input and a random TO/FROM round trip.
// Reference values come from plain modular arithmetic (x*R mod Q, x*R^-1 mod Q).

module tb_mont_conv;
    import ntt_pkg::*;

    localparam int W = DATA_WIDTH;
    localparam int R = 1 << W;
`ifdef MONT_CONV_INRED_EN
    localparam int LAT = W + 3;
`else
    localparam int LAT = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;
    longint rinv;

    mont_conv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic         mode;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint ref_model(input longint x, input logic mode);
        longint xr = x % Q;
        return mode ? (xr * rinv) % Q : (xr * R) % Q;
    endfunction

    // One full transaction; lat counts the accept edge as edge 1.
    task automatic run_op(input logic [W-1:0] x, input logic m,
                          output logic [W-1:0] res, output int lat, output bit ok);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = x;
        in_mode  = m;
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_mode  = 1'($urandom);
        ok = 1'b0;
        res = '0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            #1;
        end
        if (ok) begin
            res = out_data;
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [W-1:0] res, res2, held, x;
        int lat;
        bit ok;
        int bad;

        rinv = 0;
        for (longint v = 1; v < Q; v++) begin
            if ((v * R) % Q == 1) rinv = v;
        end

        tbl[0] = '{x: 12'd1,    mode: 1'b0, exp: 12'd767};
        tbl[1] = '{x: 12'd767,  mode: 1'b1, exp: 12'd1};
        tbl[2] = '{x: 12'd1,    mode: 1'b1, exp: 12'd2704};
        tbl[3] = '{x: 12'd0,    mode: 1'b0, exp: 12'd0};
        tbl[4] = '{x: 12'd3328, mode: 1'b0, exp: 12'd2562};
        tbl[5] = '{x: 12'd3328, mode: 1'b1, exp: 12'd625};

        // Reset state
        #12;
        check("reset_in_ready_during", 64'(in_ready), 1);
        check("reset_out_valid", 64'(out_valid), 0);
        check("reset_out_data", 64'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 64'(in_ready), 1);

        // Directed table with latency
        for (int n = 0; n < 6; n++) begin
            run_op(tbl[n].x, tbl[n].mode, res, lat, ok);
            check("table_timeout", 64'(ok), 1);
            check($sformatf("table%0d_data x=%0d m=%0d", n, tbl[n].x, tbl[n].mode), 64'(res), 64'(tbl[n].exp));
            check($sformatf("table%0d_latency", n), 64'(lat), 64'(LAT));
            $display("[TB] vec %0d x=%0d mode=%0d -> %0d lat=%0d", n, tbl[n].x, tbl[n].mode, res, lat);
        end

        // Output stall: 20 cycles of out_ready low with stray in_valid pulses
        x = W'($urandom_range(Q - 1));
        @(negedge clk);
        in_valid = 1'b1; in_data = x; in_mode = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        check("stall_timeout", 64'(ok), 1);
        held = out_data;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            in_mode  = 1'($urandom);
            if (out_data != held || in_ready != 1'b0 || out_valid != 1'b1) bad++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("stall_hold_violations", 64'(bad), 0);
        check("stall_data", 64'(held), ref_model(64'(x), 1'b0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall_release_out_valid", 64'(out_valid), 0);
        check("stall_release_in_ready", 64'(in_ready), 1);
        $display("[TB] stall x=%0d held=%0d", x, held);

        // Reset during RUN step 5
        @(negedge clk);
        in_valid = 1'b1; in_data = 12'd5; in_mode = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("midrun_reset_out_valid", 64'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_reset_in_ready", 64'(in_ready), 1);
        check("after_reset_out_valid", 64'(out_valid), 0);
        run_op(12'd1, 1'b0, res, lat, ok);
        check("after_reset_timeout", 64'(ok), 1);
        check("after_reset_tomont1", 64'(res), 767);
        check("after_reset_latency", 64'(lat), 64'(LAT));
        $display("[TB] reset-abort then x=1 -> %0d", res);

        // Out-of-range input
        run_op(12'd3330, 1'b0, res, lat, ok);
        check("oor_timeout", 64'(ok), 1);
`ifdef MONT_CONV_INRED_EN
        check("oor_3330", 64'(res), 767);
`else
        check("oor_3330_in_range", 64'(res < Q), 1);
`endif
        $display("[TB] x=3330 -> %0d", res);
        for (int n = 0; n < 8; n++) begin
            x = W'($urandom_range(R - 1, Q));
            run_op(x, 1'($urandom), res, lat, ok);
            check("oor_rand_timeout", 64'(ok), 1);
            check("oor_rand_in_range", 64'(res < Q), 1);
            $display("[TB] oor x=%0d -> %0d", x, res);
        end

        // Random round trip against the modular reference
        for (int n = 0; n < 1000; n++) begin
            x = W'($urandom_range(Q - 1));
            run_op(x, 1'b0, res, lat, ok);
            check("rt_to_timeout", 64'(ok), 1);
            check("rt_to_mont", 64'(res), ref_model(64'(x), 1'b0));
            run_op(res, 1'b1, res2, lat, ok);
            check("rt_from_timeout", 64'(ok), 1);
            check("rt_roundtrip", 64'(res2), 64'(x));
            if (n % 100 == 0) $display("[TB] rt %0d x=%0d mont=%0d back=%0d", n, x, res, res2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule
